// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports (CPU, loader) and the single-port RAM port.
// The master side is the environment (requesters plus RAM); the slave side is the arbiter.
interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_rvalid;
  logic [DATA_W-1:0] ldr_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_gnt, ldr_rvalid, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_gnt, ldr_rvalid, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester single-port RAM arbiter: same-cycle grant, alternating tie-break
// from idle, and a bounded hold so a streaming owner cannot starve the other side.
module ram_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 4
) (
  input logic         clk,
  input logic         rst,
  ram_arbiter_if.slave bus
);

  localparam int CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_OWN = 2'd1,
    LDR_OWN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sel_cpu_s, sel_ldr_s;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              ldr_rvalid_q, ldr_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= OWN_LDR;
      cnt_q        <= '0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ldr_rvalid_q <= ldr_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end

  // Grant selection plus next-state; nothing is granted while reset is held.
  always_comb begin
    sel_cpu_s = 1'b0;
    sel_ldr_s = 1'b0;
    if (rst) begin
      sel_cpu_s = 1'b0;
    end else if (bus.cpu_req && bus.ldr_req) begin
      case (state_q)
        CPU_OWN: begin
          if (cnt_q < HOLD_LIM) sel_cpu_s = 1'b1;
          else                  sel_ldr_s = 1'b1;
        end
        LDR_OWN: begin
          if (cnt_q < HOLD_LIM) sel_ldr_s = 1'b1;
          else                  sel_cpu_s = 1'b1;
        end
        default: begin
          if (last_q == OWN_LDR) sel_cpu_s = 1'b1;
          else                   sel_ldr_s = 1'b1;
        end
      endcase
    end else if (bus.cpu_req) begin
      sel_cpu_s = 1'b1;
    end else if (bus.ldr_req) begin
      sel_ldr_s = 1'b1;
    end else begin
      sel_cpu_s = 1'b0;
    end

    state_d = IDLE;
    last_d  = last_q;
    cnt_d   = '0;
    if (sel_cpu_s) begin
      state_d = CPU_OWN;
      last_d  = OWN_CPU;
      if (state_q == CPU_OWN) cnt_d = (cnt_q == HOLD_LIM) ? cnt_q : cnt_q + CNT_W'(1);
      else                    cnt_d = CNT_W'(1);
    end else if (sel_ldr_s) begin
      state_d = LDR_OWN;
      last_d  = OWN_LDR;
      if (state_q == LDR_OWN) cnt_d = (cnt_q == HOLD_LIM) ? cnt_q : cnt_q + CNT_W'(1);
      else                    cnt_d = CNT_W'(1);
    end else begin
      state_d = IDLE;
    end

    cpu_rvalid_d = sel_cpu_s && !bus.cpu_we;
    ldr_rvalid_d = sel_ldr_s && !bus.ldr_we;
    // The RAM returns data in the rvalid cycle; capture it so rdata holds afterwards.
    cpu_rdata_d  = cpu_rvalid_q ? bus.mem_rdata : cpu_rdata_q;
    ldr_rdata_d  = ldr_rvalid_q ? bus.mem_rdata : ldr_rdata_q;
  end

  // Grants, RAM command mux and read-data presentation.
  always_comb begin
    bus.cpu_gnt = sel_cpu_s;
    bus.ldr_gnt = sel_ldr_s;
    bus.mem_en  = sel_cpu_s || sel_ldr_s;
    bus.mem_we  = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    if (sel_cpu_s) begin
      bus.mem_we  = bus.cpu_we;
      mem_addr_s  = bus.cpu_addr;
      mem_wdata_s = bus.cpu_wdata;
    end else if (sel_ldr_s) begin
      bus.mem_we  = bus.ldr_we;
      mem_addr_s  = bus.ldr_addr;
      mem_wdata_s = bus.ldr_wdata;
    end else begin
      bus.mem_we  = 1'b0;
    end
    bus.mem_addr   = mem_addr_s;
    bus.mem_wdata  = mem_wdata_s;
    bus.cpu_rvalid = cpu_rvalid_q;
    bus.ldr_rvalid = ldr_rvalid_q;
    bus.cpu_rdata  = cpu_rvalid_q ? bus.mem_rdata : cpu_rdata_q;
    bus.ldr_rdata  = ldr_rvalid_q ? bus.mem_rdata : ldr_rdata_q;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 256x8 RAM (one-cycle read latency).
module tb_ram_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [7:0] ram [256];

  ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .HOLD_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic lr, input logic lw, input logic [7:0] la, input logic [7:0] ld);
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.ldr_req   = lr;
    bus.ldr_we    = lw;
    bus.ldr_addr  = la;
    bus.ldr_wdata = ld;
  endtask

  // One cycle: inputs change just after the rising edge, outputs are checked at the falling edge.
  task automatic cyc(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                     input logic lr, input logic lw, input logic [7:0] la, input logic [7:0] ld);
    @(posedge clk);
    #1;
    drive(cr, cw, ca, cd, lr, lw, la, ld);
    #4;
  endtask

  initial begin
    logic exp_l;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[128] = 8'd6;
    ram[3]   = 8'h33;
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'd128, 8'd0, 1'b1, 1'b0, 8'd3, 8'd0);

    cyc(1'b1, 1'b0, 8'd128, 8'd0, 1'b1, 1'b0, 8'd3, 8'd0);
    chk("rst_cpu_gnt", bus.cpu_gnt, 1'b0);
    chk("rst_ldr_gnt", bus.ldr_gnt, 1'b0);
    chk("rst_mem_en", bus.mem_en, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    chk("rst_ldr_rvalid", bus.ldr_rvalid, 1'b0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 8'd0);
    chk("rst_ldr_rdata", bus.ldr_rdata, 8'd0);

    // Tie right after reset release goes to the CPU, then ties from idle alternate.
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'd128, 8'd0, 1'b1, 1'b0, 8'd3, 8'd0);
    #4;
    chk("tie1_cpu_gnt", bus.cpu_gnt, 1'b1);
    chk("tie1_ldr_gnt", bus.ldr_gnt, 1'b0);
    chk("tie1_mem_addr", bus.mem_addr, 8'd128);
    chk("tie1_mem_en", bus.mem_en, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0);
    chk("idle_mem_en", bus.mem_en, 1'b0);
    chk("tie1_cpu_rvalid", bus.cpu_rvalid, 1'b1);
    chk("tie1_cpu_rdata", bus.cpu_rdata, 8'd6);
    chk("tie1_ldr_rvalid", bus.ldr_rvalid, 1'b0);
    cyc(1'b1, 1'b0, 8'd128, 8'd0, 1'b1, 1'b0, 8'd3, 8'd0);
    chk("tie2_ldr_gnt", bus.ldr_gnt, 1'b1);
    chk("tie2_cpu_gnt", bus.cpu_gnt, 1'b0);
    chk("tie2_mem_addr", bus.mem_addr, 8'd3);
    cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0);
    chk("tie2_ldr_rvalid", bus.ldr_rvalid, 1'b1);
    chk("tie2_ldr_rdata", bus.ldr_rdata, 8'h33);
    chk("tie2_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    chk("cpu_rdata_hold", bus.cpu_rdata, 8'd6);
    cyc(1'b1, 1'b0, 8'd128, 8'd0, 1'b1, 1'b0, 8'd3, 8'd0);
    chk("tie3_cpu_gnt", bus.cpu_gnt, 1'b1);
    chk("tie3_ldr_gnt", bus.ldr_gnt, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0);

    // Single requester read.
    cyc(1'b1, 1'b0, 8'd128, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0);
    chk("single_cpu_gnt", bus.cpu_gnt, 1'b1);
    chk("single_ldr_gnt", bus.ldr_gnt, 1'b0);
    chk("single_mem_we", bus.mem_we, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0);
    chk("single_rvalid", bus.cpu_rvalid, 1'b1);
    chk("single_rdata", bus.cpu_rdata, 8'd6);
    chk("single_ldr_gnt2", bus.ldr_gnt, 1'b0);

    // Hold limit: loader owns, then both stream; expect LLLL CCCC LLLL.
    cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd3, 8'd0);
    chk("hold0_ldr_gnt", bus.ldr_gnt, 1'b1);
    for (int i = 1; i < 12; i++) begin
      cyc(1'b1, 1'b0, 8'd128, 8'd0, 1'b1, 1'b0, 8'd3, 8'd0);
      exp_l = (i < 4) || (i >= 8);
      chk($sformatf("hold%0d_ldr_gnt", i), bus.ldr_gnt, exp_l);
      chk($sformatf("hold%0d_cpu_gnt", i), bus.cpu_gnt, !exp_l);
    end
    cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0);

    // Loader program load of 11 bytes; writes never raise rvalid.
    for (int i = 0; i < 11; i++) begin
      cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 8'(i), 8'(8'hA0 + i));
      chk($sformatf("load%0d_gnt", i), bus.ldr_gnt, 1'b1);
      chk($sformatf("load%0d_we", i), bus.mem_we, 1'b1);
      chk($sformatf("load%0d_addr", i), bus.mem_addr, 8'(i));
      chk($sformatf("load%0d_wdata", i), bus.mem_wdata, 8'(8'hA0 + i));
      chk($sformatf("load%0d_rvalid", i), bus.ldr_rvalid, 1'b0);
    end
    cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0);
    chk("load_end_rvalid", bus.ldr_rvalid, 1'b0);
    chk("ldr_rdata_hold", bus.ldr_rdata, 8'h33);
    cyc(1'b1, 1'b0, 8'd5, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0);
    chk("rd5_gnt", bus.cpu_gnt, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0);
    chk("rd5_rvalid", bus.cpu_rvalid, 1'b1);
    chk("rd5_rdata", bus.cpu_rdata, 8'hA5);

    // Cross-port read-after-write.
    cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 8'd10, 8'hF0);
    chk("raw_wr_gnt", bus.ldr_gnt, 1'b1);
    cyc(1'b1, 1'b0, 8'd10, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0);
    chk("raw_rd_gnt", bus.cpu_gnt, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0);
    chk("raw_rvalid", bus.cpu_rvalid, 1'b1);
    chk("raw_rdata", bus.cpu_rdata, 8'hF0);

    // Reset in the cycle after a granted read kills the rvalid.
    cyc(1'b1, 1'b0, 8'd128, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0);
    chk("mid_rd_gnt", bus.cpu_gnt, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0);
    #4;
    chk("mid_rst_rvalid", bus.cpu_rvalid, 1'b0);
    chk("mid_rst_rdata", bus.cpu_rdata, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'd128, 8'd0, 1'b1, 1'b0, 8'd3, 8'd0);
    #4;
    chk("post_rst_cpu_gnt", bus.cpu_gnt, 1'b1);
    chk("post_rst_ldr_gnt", bus.ldr_gnt, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0);
    chk("post_rst_rdata", bus.cpu_rdata, 8'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the RAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the RAM data width.
REQ-003 The block SHALL have parameter HOLD_MAX, default 4, meaning the maximum consecutive grants to one requester while the other is waiting.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have CPU request ports: cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_W, cpu_wdata in DATA_W.
REQ-007 The block SHALL have CPU response ports: cpu_gnt out 1, cpu_rvalid out 1, cpu_rdata out DATA_W.
REQ-008 The block SHALL have loader request ports: ldr_req in 1, ldr_we in 1, ldr_addr in ADDR_W, ldr_wdata in DATA_W.
REQ-009 The block SHALL have loader response ports: ldr_gnt out 1, ldr_rvalid out 1, ldr_rdata out DATA_W.
REQ-010 The block SHALL have RAM ports: mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W; mem_rdata is valid one cycle after a read access.

Function
REQ-011 The block SHALL hold a registered FSM with states IDLE, CPU_OWN, LDR_OWN, a registered last_owner bit (CPU/LDR) and a hold counter of width ceil(log2(HOLD_MAX+1)).
REQ-012 Each cycle the block SHALL select at most one requester combinationally from the inputs and registered state; the selected requester's gnt is high that same cycle.
REQ-013 Only one requesting: that requester SHALL be selected.
REQ-014 Both requesting, in IDLE: the requester not equal to last_owner SHALL be selected.
REQ-015 Both requesting, in X_OWN with hold counter < HOLD_MAX: X SHALL be selected again; with counter = HOLD_MAX, the other requester SHALL be selected.
REQ-016 No request: no gnt; mem_en = 0; the next state SHALL be IDLE and the counter SHALL clear to 0.
REQ-017 When X is selected, the next state SHALL be X_OWN and last_owner SHALL become X. The counter SHALL increment (saturating at HOLD_MAX) if the state was already X_OWN, else load 1.
REQ-018 On a grant, mem_en SHALL be 1, and mem_we/mem_addr/mem_wdata SHALL equal the granted requester's we/addr/wdata in the same cycle.
REQ-019 A granted read (we = 0) SHALL assert that requester's rvalid for exactly the next cycle, with its rdata = mem_rdata of that cycle.
REQ-020 A granted write SHALL produce no rvalid.
REQ-021 rdata SHALL hold its last value while rvalid is low.
REQ-022 gnt SHALL never be high for both requesters in one cycle, and never for a requester whose req is low.
REQ-023 Requests are not queued: an ungranted requester SHALL keep req and its address/data stable until gnt; dropping req withdraws the request with no side effect.
REQ-024 A read by one requester in the cycle after a write by the other to the same address SHALL return the new data.

Reset
REQ-025 While rst is high, state SHALL be IDLE, last_owner = LDR (CPU wins the first tie), counter = 0, both gnt = 0, both rvalid = 0, both rdata = 0, mem_en = 0, mem_we = 0.
REQ-026 Reset asserted mid-operation SHALL take effect immediately: a read granted in the cycle before reset SHALL produce no rvalid.
REQ-027 The first cycle after rst deasserts SHALL arbitrate normally.

Verification
REQ-028 Single requester: CPU reads addr 128 holding 6 -> cpu_gnt that cycle, next cycle cpu_rvalid = 1 and cpu_rdata = 6, ldr_gnt stays 0.
REQ-029 Tie after reset: both requesters request from the first cycle -> CPU is granted first, then CPU, LDR alternately while in IDLE-tie situations.
REQ-030 Hold limit: both requesters assert continuously after LDR_OWN is established -> LDR is granted exactly 4 consecutive cycles, then CPU is granted 4, repeating with HOLD_MAX = 4.
REQ-031 Loader program load: loader writes 11 bytes to addr 0-10, then the CPU reads addr 5 -> cpu_rdata = byte written at 5, with no rvalid on any write.
REQ-032 Cross-port RAW: LDR writes 0xF0 to addr 10, and the CPU reads addr 10 in the next cycle -> cpu_rdata = 0xF0.
REQ-033 Reset mid-read: assert rst in the cycle after a granted CPU read -> cpu_rvalid = 0, cpu_rdata = 0, and after release the first tie goes to the CPU.
